// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_seq_pkg
// Brief  : Shared datapath types and constants for the sequential divider.
// Rev    : 1.0  initial release
// ============================================================================
package div_seq_pkg;

    localparam int DIV_WIDTH_DEF = 32;

    // Result select shared with the multiply write-back path
    localparam logic c_RES_SEL_LO = 1'b0;
    localparam logic c_RES_SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division step on a WIDTH+1 remainder.
// Rev    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_div_ext;

    assign w_shift   = {i_rem[WIDTH-1:0], i_dvd_msb};
    assign w_div_ext = {1'b0, i_div};

    // A set top bit means the shifted value already exceeds any divisor
    assign o_q_bit = i_rem[WIDTH] | (w_shift >= w_div_ext);
    assign o_rem   = o_q_bit ? (w_shift - w_div_ext) : w_shift;

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module : div_seq
// Brief  : Iterative WIDTH-cycle restoring divider (signed/unsigned) with
//          start/busy/done handshake producing quotient (LO) and remainder (HI).
// Rev    : 1.0  initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             isSigned,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    div_state_t         r_state;
    div_state_t         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic               r_qs;
    logic               r_rs;
    logic               r_dz;
    logic               r_done;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_rem_next;
    logic               w_q_bit;
    logic               w_last;

    assign w_a_mag = (isSigned && a[WIDTH-1]) ? (-a) : a;
    assign w_b_mag = (isSigned && b[WIDTH-1]) ? (-b) : b;
    assign w_last  = (r_cnt == c_CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd_msb (r_dvd[WIDTH-1]),
        .i_div     (r_div),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CALC;
            S_CALC:  if (w_last) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_qs   <= 1'b0;
            r_rs   <= 1'b0;
            r_dz   <= 1'b0;
            r_done <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd  <= w_a_mag;
                        r_div  <= w_b_mag;
                        r_qs   <= isSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_rs   <= isSigned & a[WIDTH-1];
                        r_dz   <= (b == '0);
                        r_rem  <= '0;
                        r_quot <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_CALC: begin
                    r_rem  <= w_rem_next;
                    r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_quot <= {r_quot[WIDTH-2:0], w_q_bit};
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    // On divide by zero rem = |a|, so negating it restores a;
                    // only the quotient must stay all ones.
                    r_q    <= (r_qs && !r_dz) ? (-r_quot) : r_quot;
                    r_r    <= r_rs ? (-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_div_seq
// Brief  : Self-checking directed bench for div_seq with a result scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_div_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        isSigned;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cycles;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .isSigned (isSigned),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference built on the language's truncating / and %
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
        exp_t e;
        if (mb == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = ma;
        end else if (ms && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (ms) begin
            e.q = $signed(ma) / $signed(mb);
            e.r = $signed(ma) % $signed(mb);
        end else begin
            e.q = ma / mb;
            e.r = ma % mb;
        end
        return e;
    endfunction

    // Drive a start that the DUT samples on the next edge; optionally score it
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input logic push, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        start    = 1'b1;
        a        = ia;
        b        = ib;
        isSigned = is;
        if (push) begin
            e.q = eq;
            e.r = er;
            sb.push_back(e);
        end
        tick();
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        isSigned = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n           = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
            if (busy === 1'b1) busy_cycles++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_q"}, q, e.q);
            check({tag, "_r"}, r, e.r);
        end else begin
            check({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end
    endtask

    initial begin
        exp_t m;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          seen;

        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        isSigned = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_q", q, 32'd0);
        check("reset_r", r, 32'd0);
        rst = 1'b0;
        tick();

        // 100 / 7 unsigned with latency and busy-window checks
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);
        check("u100_busy_e0", 32'(busy), 32'd1);
        wait_done("u100", 33);
        check("u100_busy_cycles", 32'(busy_cycles + 1), 32'd33);
        check("u100_busy_at_done", 32'(busy), 32'd0);
        tick();
        check("u100_done_pulse", 32'(done), 32'd0);
        check("u100_q_hold", q, 32'd14);

        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_done("s_m7_2", 33);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1);
        wait_done("s_7_m2", 33);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0);
        wait_done("s_ovf", 33);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000);
        wait_done("u_ovf", 33);
        issue(32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5);
        wait_done("u_dz", 33);
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        wait_done("s_dz", 33);

        // Start while busy is ignored; start in done cycle is accepted
        issue(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0);
        repeat (4) tick();
        start = 1'b1; a = 32'd55; b = 32'd3; isSigned = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign_start", 28);
        issue(32'd77, 32'd5, 1'b0, 1'b1, 32'd15, 32'd2);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b", 33);

        // Reset at cycle 10 of CALC discards the operation
        issue(32'd123456, 32'd789, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        issue(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0);
        wait_done("post_rst", 33);

        // A few random operands against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 0) ? 32'($urandom_range(1, 200)) : $urandom;
            rs = 1'(i % 2);
            m  = model(ra, rb, rs);
            issue(ra, rb, rs, 1'b1, m.q, m.r);
            wait_done($sformatf("rand%0d", i), 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_seq
`default_nettype wire
